mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants the port to one requester at a time and drives a registered bus request to memory.
- Returns read data to the owner with a one-cycle valid pulse.
- Generates stall_IF / stall_MEM for the pipeline hazard logic while a requester waits or is in flight.

Parameters:
ADDR_W, 32, address width of requesters and bus
DATA_W, 32, data width
STARVE_MAX, 4, consecutive IF losses before IF is forced priority (only with ARB_FAIRNESS_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  IF read request; held with if_addr stable until if_valid
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched instruction, valid when if_valid
if_valid  output  1  one-cycle pulse, fetch complete
mem_req  input  1  MEM request; held with all MEM inputs stable until mem_valid
mem_we  input  1  1 = store, 0 = load
mem_addr  input  ADDR_W  data address
mem_wdata  input  DATA_W  store data
mem_be  input  DATA_W/8  byte enables
mem_rdata  output  DATA_W  load data, valid when mem_valid and load
mem_valid  output  1  one-cycle pulse, MEM access complete
bus_req  output  1  request to memory, registered
bus_we  output  1  registered
bus_addr  output  ADDR_W  registered
bus_wdata  output  DATA_W  registered
bus_be  output  DATA_W/8  registered; all-ones for IF
bus_ack  input  1  memory completes the current access this cycle
bus_rdata  input  DATA_W  read data, qualified by bus_ack
stall_IF  output  1  if_req && !if_valid (combinational)
stall_MEM  output  1  mem_req && !mem_valid (combinational)
owner  output  2  0 = none, 1 = IF, 2 = MEM (debug)

Behaviour:
- Reset (asynchronous): state IDLE; bus_req, bus_we, if_valid, mem_valid = 0; bus_addr, bus_wdata, if_rdata, mem_rdata = 0; bus_be = 0; owner = 0; starve counter = 0.
- Reset mid-transaction abandons the access. A bus_ack arriving in IDLE is ignored.
- FSM states: IDLE, SERVE_IF, SERVE_MEM.
- IDLE arbitration (default priority):
  - mem_req: load bus_* from MEM inputs, bus_req <= 1, go to SERVE_MEM.
  - else if_req: load bus_addr <= if_addr, bus_we <= 0, bus_be <= all ones, bus_req <= 1, go to SERVE_IF.
  - else stay in IDLE.
- SERVE_x: bus_* are held constant until bus_ack. On bus_ack:
  - bus_req <= 0 and return to IDLE.
  - x_valid <= 1 for exactly the next cycle.
  - if_rdata / mem_rdata <= bus_rdata; mem_rdata is updated only when the access was a load, otherwise held.
- Valid-cycle rule: in the cycle x_valid is high, the FSM is in IDLE, and x_req sampled that cycle is treated as a new request.
- Minimum cost per access is 2 cycles (issue + ack) plus 1 IDLE cycle. With bus_ack on the first cycle of bus_req, back-to-back throughput is one access per 2 cycles.
- Simultaneous if_req and mem_req in IDLE: MEM wins. IF keeps waiting with stall_IF = 1.
- Request deassertion while in SERVE_x is illegal. The access completes regardless and the valid pulse is still generated.
- if_valid and mem_valid are never high in the same cycle.
- owner reflects the current state: IDLE = 0, SERVE_IF = 1, SERVE_MEM = 2.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit saturating starve counter increments each IDLE arbitration where if_req = 1 and MEM is granted.
  - It clears when IF is granted or if_req = 0.
  - When the counter equals STARVE_MAX, IF wins the next simultaneous arbitration, then the counter clears.
- Undefined: strict MEM priority; no counter logic.

Test Plan:
- Reset then if_req = 1, if_addr = 0x100, bus_ack one cycle after bus_req, bus_rdata = 0x00500093 -> bus_addr = 0x100, bus_be = 0xF; if_valid pulses once with if_rdata = 0x00500093; stall_IF = 1 until that cycle.
- if_req and mem_req both 1 in IDLE, load from 0x2000 returning 0xDEADBEEF -> MEM served first (owner = 2), mem_rdata = 0xDEADBEEF; IF served in the next IDLE; stall_IF = 1 throughout.
- Store mem_we = 1, mem_addr = 0x40, mem_wdata = 0x12345678, mem_be = 0x3, bus_ack delayed 3 cycles -> bus_* held stable 4 cycles; mem_valid pulses once; mem_rdata unchanged.
- Reset asserted during SERVE_MEM before bus_ack -> bus_req = 0 immediately; no mem_valid; a late bus_ack produces no valid.
- mem_req held continuously with if_req = 1 -> without ARB_FAIRNESS_EN, IF never granted; with it, IF granted after 4 consecutive MEM grants.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-bus signal bundle for mem_port_arbiter
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_valid;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_valid;

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;

    logic                  stall_IF;
    logic                  stall_MEM;
    logic [1:0]            owner;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_valid,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata,
        output stall_IF, stall_MEM, owner
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_valid,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata,
        input  stall_IF, stall_MEM, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF fetch and MEM load/store
// Optional IF anti-starvation under macro ARB_FAIRNESS_EN (default: strict MEM priority).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave ifc
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } state_t;

    // The starve counter is 3 bits, so the threshold must fit in it.
    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_max_range
        $error("STARVE_MAX must be within 1..7");
    end

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]     bus_be_q, bus_be_d;
    logic                if_valid_q, if_valid_d;
    logic                mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic [1:0]          owner_q, owner_d;

    logic                arb_idle;
    logic                force_if;
    logic                grant_mem;
    logic                grant_if;

`ifdef ARB_FAIRNESS_EN
    logic [2:0]          starve_q, starve_d;

    assign force_if = ifc.if_req && ifc.mem_req && (starve_q == 3'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!ifc.if_req || grant_if) begin
            starve_d = 3'd0;
        end else if (grant_mem && starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign arb_idle  = (state_q == IDLE);
    assign grant_mem = arb_idle && ifc.mem_req && !force_if;
    assign grant_if  = arb_idle && ifc.if_req && !grant_mem;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = ifc.mem_we;
                    bus_addr_d  = ifc.mem_addr;
                    bus_wdata_d = ifc.mem_wdata;
                    bus_be_d    = ifc.mem_be;
                    state_d     = SERVE_MEM;
                end else if (grant_if) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = ifc.if_addr;
                    bus_be_d    = {BE_W{1'b1}};
                    state_d     = SERVE_IF;
                end
            end
            SERVE_IF: begin
                if (ifc.bus_ack) begin
                    bus_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = ifc.bus_rdata;
                    state_d    = IDLE;
                end
            end
            SERVE_MEM: begin
                if (ifc.bus_ack) begin
                    bus_req_d   = 1'b0;
                    mem_valid_d = 1'b1;
                    // Stores leave the last load result visible to the pipeline.
                    if (!bus_we_q) begin
                        mem_rdata_d = ifc.bus_rdata;
                    end
                    state_d     = IDLE;
                end
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        owner_d = 2'(state_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            owner_q     <= 2'd0;
`ifdef ARB_FAIRNESS_EN
            starve_q    <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            owner_q     <= owner_d;
`ifdef ARB_FAIRNESS_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign ifc.bus_req   = bus_req_q;
    assign ifc.bus_we    = bus_we_q;
    assign ifc.bus_addr  = bus_addr_q;
    assign ifc.bus_wdata = bus_wdata_q;
    assign ifc.bus_be    = bus_be_q;
    assign ifc.if_valid  = if_valid_q;
    assign ifc.if_rdata  = if_rdata_q;
    assign ifc.mem_valid = mem_valid_q;
    assign ifc.mem_rdata = mem_rdata_q;
    assign ifc.owner     = owner_q;
    assign ifc.stall_IF  = ifc.if_req && !if_valid_q;
    assign ifc.stall_MEM = ifc.mem_req && !mem_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
// Expected completions are queued when a request is driven and popped on each valid pulse.
module tb_mem_port_arbiter;
    logic clock;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .ifc   (ifc.slave)
    );

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_mem, input logic [31:0] data);
        exp_t e;
        e.is_mem = is_mem;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic check_valid();
        exp_t e;
        chk("one_valid", 64'(ifc.if_valid & ifc.mem_valid), 64'd0);
        chk("valid_seen", 64'(ifc.if_valid | ifc.mem_valid), 64'd1);
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0 && (ifc.if_valid || ifc.mem_valid)) begin
            e = sb.pop_front();
            chk("valid_port", 64'(ifc.mem_valid), 64'(e.is_mem));
            chk("rdata", 64'(e.is_mem ? ifc.mem_rdata : ifc.if_rdata), 64'(e.data));
        end
    endtask

    task automatic do_ack(input int delay, input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic exp_we, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_be, input logic [1:0] exp_owner);
        for (int i = 0; i <= delay; i++) begin
            chk("hold_req", 64'(ifc.bus_req), 64'd1);
            chk("hold_addr", 64'(ifc.bus_addr), 64'(exp_addr));
            chk("hold_we", 64'(ifc.bus_we), 64'(exp_we));
            chk("hold_be", 64'(ifc.bus_be), 64'(exp_be));
            chk("hold_owner", 64'(ifc.owner), 64'(exp_owner));
            if (exp_we) chk("hold_wdata", 64'(ifc.bus_wdata), 64'(exp_wdata));
            if (i == delay) begin
                ifc.bus_ack   = 1'b1;
                ifc.bus_rdata = rdata;
            end
            tick();
        end
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = 32'h0;
    endtask

    initial begin
        int  mem_grants;
        bit  if_granted;

        reset          = 1'b1;
        ifc.if_req     = 1'b0;
        ifc.if_addr    = 32'h0;
        ifc.mem_req    = 1'b0;
        ifc.mem_we     = 1'b0;
        ifc.mem_addr   = 32'h0;
        ifc.mem_wdata  = 32'h0;
        ifc.mem_be     = 4'h0;
        ifc.bus_ack    = 1'b0;
        ifc.bus_rdata  = 32'h0;
        tick();
        tick();

        chk("rst_bus_req", 64'(ifc.bus_req), 64'd0);
        chk("rst_bus_addr", 64'(ifc.bus_addr), 64'd0);
        chk("rst_bus_be", 64'(ifc.bus_be), 64'd0);
        chk("rst_owner", 64'(ifc.owner), 64'd0);
        chk("rst_valids", 64'({ifc.if_valid, ifc.mem_valid}), 64'd0);
        chk("rst_rdata", 64'({ifc.if_rdata, ifc.mem_rdata}), 64'd0);
        reset = 1'b0;

        // Single fetch, ack one cycle after the request appears.
        ifc.if_req  = 1'b1;
        ifc.if_addr = 32'h100;
        push_exp(1'b0, 32'h0050_0093);
        #1;
        chk("t1_stall_if_pre", 64'(ifc.stall_IF), 64'd1);
        chk("t1_no_bus_yet", 64'(ifc.bus_req), 64'd0);
        tick();
        chk("t1_stall_if", 64'(ifc.stall_IF), 64'd1);
        do_ack(1, 32'h0050_0093, 32'h100, 1'b0, 32'h0, 4'hF, 2'd1);
        check_valid();
        chk("t1_stall_if_done", 64'(ifc.stall_IF), 64'd0);
        chk("t1_owner_idle", 64'(ifc.owner), 64'd0);
        ifc.if_req = 1'b0;
        tick();
        chk("t1_valid_pulse", 64'(ifc.if_valid), 64'd0);
        chk("t1_bus_idle", 64'(ifc.bus_req), 64'd0);

        // Simultaneous requests: MEM load first, IF afterwards.
        ifc.if_req   = 1'b1;
        ifc.if_addr  = 32'h104;
        ifc.mem_req  = 1'b1;
        ifc.mem_we   = 1'b0;
        ifc.mem_addr = 32'h2000;
        ifc.mem_be   = 4'hF;
        push_exp(1'b1, 32'hDEAD_BEEF);
        push_exp(1'b0, 32'hCAFE_0001);
        tick();
        chk("t2_stall_if", 64'(ifc.stall_IF), 64'd1);
        chk("t2_stall_mem", 64'(ifc.stall_MEM), 64'd1);
        do_ack(0, 32'hDEAD_BEEF, 32'h2000, 1'b0, 32'h0, 4'hF, 2'd2);
        check_valid();
        chk("t2_stall_if_wait", 64'(ifc.stall_IF), 64'd1);
        chk("t2_stall_mem_done", 64'(ifc.stall_MEM), 64'd0);
        ifc.mem_req = 1'b0;
        tick();
        chk("t2_stall_if_serve", 64'(ifc.stall_IF), 64'd1);
        do_ack(0, 32'hCAFE_0001, 32'h104, 1'b0, 32'h0, 4'hF, 2'd1);
        check_valid();
        ifc.if_req = 1'b0;
        tick();

        // Store with delayed ack; load data register must keep its value.
        ifc.mem_req   = 1'b1;
        ifc.mem_we    = 1'b1;
        ifc.mem_addr  = 32'h40;
        ifc.mem_wdata = 32'h1234_5678;
        ifc.mem_be    = 4'h3;
        push_exp(1'b1, 32'hDEAD_BEEF);
        tick();
        do_ack(3, 32'hBAD0_BAD0, 32'h40, 1'b1, 32'h1234_5678, 4'h3, 2'd2);
        check_valid();
        ifc.mem_req = 1'b0;
        ifc.mem_we  = 1'b0;
        tick();
        chk("t3_valid_pulse", 64'(ifc.mem_valid), 64'd0);

        // Reset while a load is outstanding, then a stray ack.
        ifc.mem_req  = 1'b1;
        ifc.mem_addr = 32'h80;
        ifc.mem_be   = 4'hF;
        tick();
        chk("t4_inflight", 64'(ifc.bus_req), 64'd1);
        reset = 1'b1;
        #1;
        chk("t4_async_bus_req", 64'(ifc.bus_req), 64'd0);
        chk("t4_async_owner", 64'(ifc.owner), 64'd0);
        chk("t4_mem_rdata", 64'(ifc.mem_rdata), 64'd0);
        ifc.mem_req = 1'b0;
        tick();
        reset = 1'b0;
        ifc.bus_ack   = 1'b1;
        ifc.bus_rdata = 32'h5555_5555;
        tick();
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = 32'h0;
        chk("t4_late_ack_valid", 64'({ifc.if_valid, ifc.mem_valid}), 64'd0);
        chk("t4_late_ack_bus", 64'(ifc.bus_req), 64'd0);
        tick();
        chk("t4_late_ack_valid2", 64'({ifc.if_valid, ifc.mem_valid}), 64'd0);

        // MEM held continuously against a waiting IF.
        ifc.mem_req  = 1'b1;
        ifc.mem_we   = 1'b0;
        ifc.mem_addr = 32'h300;
        ifc.mem_be   = 4'hF;
        ifc.if_req   = 1'b1;
        ifc.if_addr  = 32'h400;
        mem_grants   = 0;
        if_granted   = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (ifc.owner === 2'd1) begin
                if_granted = 1'b1;
                break;
            end
            chk("t5_owner_mem", 64'(ifc.owner), 64'd2);
            chk("t5_stall_if", 64'(ifc.stall_IF), 64'd1);
            mem_grants++;
            push_exp(1'b1, 32'h1000 + 32'(n));
            do_ack(0, 32'h1000 + 32'(n), 32'h300, 1'b0, 32'h0, 4'hF, 2'd2);
            check_valid();
        end
`ifdef ARB_FAIRNESS_EN
        chk("t5_mem_grants", 64'(mem_grants), 64'd4);
        chk("t5_if_granted", 64'(if_granted), 64'd1);
`else
        chk("t5_mem_grants", 64'(mem_grants), 64'd10);
        chk("t5_if_granted", 64'(if_granted), 64'd0);
`endif
        if (if_granted) begin
            push_exp(1'b0, 32'h0000_0077);
            do_ack(0, 32'h0000_0077, 32'h400, 1'b0, 32'h0, 4'hF, 2'd1);
            check_valid();
        end
        ifc.mem_req = 1'b0;
        ifc.if_req  = 1'b0;
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
